// File: rtl/run_pkg.sv
// Shared types and defaults for the run sequencer and its address walker.
package run_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FINISH} seq_state_t;

    localparam int DEF_AW = 8;
    localparam int DEF_CW = 20;

    // Instruction word the core treats as "done"; used by the core model in the bench.
    localparam logic [8:0] DONE_OPCODE = 9'b101111111;
endpackage

// File: rtl/stream_addr_walker.sv
// base+ptr address generator with end-of-window compare; shared by preload and drain.
// Purely combinational; address wraps modulo 2^AW.
module stream_addr_walker
    import run_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [AW:0]   ptr,
    output logic [AW-1:0] addr,
    output logic          last
);
    assign addr = base + ptr[AW-1:0];
    assign last = (ptr == len - 1'b1);
endmodule

// File: rtl/run_sequencer.sv
// Run controller: preload data memory, release the core until done or budget, drain a result window.
// Handshake outputs are decoded from the registered state; the pointer advances only on accepted bytes.
module run_sequencer
    import run_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_LEN   = 64,
    parameter int DRAIN_BASE = 64,
    parameter int DRAIN_LEN  = 32,
    parameter int CW         = DEF_CW,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          inValid,
    input  logic [7:0]    inData,
    output logic          inReady,
    output logic          coreReset,
    input  logic          coreDone,
    output logic          memSel,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [7:0]    memWData,
    input  logic [7:0]    memRData,
    output logic          outValid,
    output logic [7:0]    outData,
    output logic          outLast,
    input  logic          outReady,
    output logic          busy,
    output logic          runDone,
    output logic          timedOut,
    output logic [CW-1:0] cycleCount
);
    localparam logic [AW:0]   LOAD_LEN_W   = (AW+1)'(LOAD_LEN);
    localparam logic [AW:0]   DRAIN_LEN_W  = (AW+1)'(DRAIN_LEN);
    localparam logic [AW-1:0] LOAD_BASE_W  = AW'(LOAD_BASE);
    localparam logic [AW-1:0] DRAIN_BASE_W = AW'(DRAIN_BASE);
    localparam logic [CW-1:0] MAX_W        = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] LAST_CYC_W   = CW'(MAX_CYCLES - 1);

    seq_state_t    state, state_nx;
    logic [AW:0]   ptr, ptr_nx;
    logic [CW-1:0] cnt_nx;
    logic          to_nx;
    logic [AW-1:0] walk_base;
    logic [AW:0]   walk_len;
    logic [AW-1:0] walk_addr;
    logic          walk_last;

    // LOAD and DRAIN never overlap, so one walker serves both windows.
    assign walk_base = (state == DRAIN) ? DRAIN_BASE_W : LOAD_BASE_W;
    assign walk_len  = (state == DRAIN) ? DRAIN_LEN_W  : LOAD_LEN_W;

    stream_addr_walker #(.AW(AW)) u_walker (
        .base (walk_base),
        .len  (walk_len),
        .ptr  (ptr),
        .addr (walk_addr),
        .last (walk_last)
    );

    assign memAddr  = walk_addr;
    assign memWData = inData;
    assign outData  = memRData;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cycleCount <= '0;
            timedOut   <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            cycleCount <= cnt_nx;
            timedOut   <= to_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cnt_nx    = cycleCount;
        to_nx     = timedOut;
        coreReset = 1'b1;
        memSel    = 1'b1;
        memWe     = 1'b0;
        inReady   = 1'b0;
        outValid  = 1'b0;
        outLast   = 1'b0;
        runDone   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    to_nx    = 1'b0;
                    cnt_nx   = '0;
                    ptr_nx   = '0;
                    state_nx = (LOAD_LEN == 0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                inReady = 1'b1;
                memWe   = inValid;
                if (inValid) begin
                    if (walk_last) begin
                        ptr_nx   = '0;
                        state_nx = RUN;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
            end
            RUN: begin
                coreReset = 1'b0;
                memSel    = 1'b0;
                if (cycleCount != MAX_W) begin
                    cnt_nx = cycleCount + 1'b1;
                end
                // A zero count marks the first RUN cycle, when the core is still held.
                if (coreDone && (cycleCount != '0)) begin
                    state_nx = DRAIN;
                end else if (cycleCount == LAST_CYC_W) begin
                    to_nx    = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (DRAIN_LEN == 0) begin
                    state_nx = FINISH;
                end else begin
                    outValid = 1'b1;
                    outLast  = walk_last;
                    if (outReady) begin
                        if (walk_last) begin
                            ptr_nx   = '0;
                            state_nx = FINISH;
                        end else begin
                            ptr_nx = ptr + 1'b1;
                        end
                    end
                end
            end
            FINISH: begin
                runDone  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
